// File: rtl/sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_ctrl_if -- CPU-side load/store bus between the EXE/MEM pipeline
// boundary and the 16-bit SRAM controller.
//
// Signals:
//   wr_en       store request (level, held until ready)
//   rd_en       load request  (level, held until ready)
//   address     32-bit byte address
//   write_data  32-bit store data
//   read_data   32-bit load data, valid while ready=1 after a read
//   ready       0 = freeze the pipeline, 1 = done or nothing pending
//   addr_err    illegal-address flag (only when address checking is built in)
//
// Modports:
//   master  pipeline side (drives requests)
//   slave   controller side (returns data and handshake)
// ---------------------------------------------------------------------------
interface sram_ctrl_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        addr_err;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready, addr_err
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready, addr_err
  );
endinterface

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl -- turns one 32-bit load/store into two 16-bit SRAM accesses
// (low half, then high half), each stretched by WAIT_CYCLES extra cycles,
// and stalls the pipeline through ready until the access finishes.
//
// Parameters:
//   WAIT_CYCLES  extra cycles per 16-bit half access (1..7)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus          sram_ctrl_if.slave: wr_en, rd_en, address, write_data in;
//                read_data, ready, addr_err out
//   sram_addr    SRAM half-word address
//   sram_we_n    SRAM write strobe, active low
//   sram_dq_out  SRAM write data
//   sram_dq_oe   SRAM data drive enable
//   sram_dq_in   SRAM read data
//
// Build option:
//   SRAM_CTRL_ADDR_CHECK_EN  when defined, misaligned addresses and
//   addresses outside [1024, 1024+2^19) are rejected: the request goes
//   straight to DONE with addr_err=1 and no SRAM activity. When undefined,
//   addr_err is constant 0 and unmapped address bits are ignored.
//
// Byte address A maps to word (A-1024)>>2; its low half lives at SRAM
// address {word,0} and its high half at {word,1}.
// ---------------------------------------------------------------------------
module sram_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  sram_ctrl_if.slave        bus,
  output logic [17:0]       sram_addr,
  output logic              sram_we_n,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  localparam logic [2:0] LP_WAIT = 3'(WAIT_CYCLES);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_is_write;
  logic [16:0] r_word;
  logic [31:0] r_wdata;
  logic [31:0] r_read_data;
  logic        r_addr_err;
  logic [17:0] r_sram_addr;
  logic        r_sram_we_n;
  logic [15:0] r_sram_dq_out;
  logic        r_sram_dq_oe;

  logic        w_req;
  logic        w_req_write;
  logic [16:0] w_word;
  logic [2:0]  w_cnt_inc;
  logic        w_we_n_next;
  logic        w_addr_bad;

  assign w_req       = bus.wr_en | bus.rd_en;
  // A simultaneous read and write request is served as a write.
  assign w_req_write = bus.wr_en;
  // (A-1024)>>2 only depends on A[18:2] modulo 2^17; 1024>>2 = 256.
  assign w_word      = bus.address[18:2] - 17'd256;
  assign w_cnt_inc   = r_cnt + 3'd1;
  // Strobe value for the next cycle while still counting within a half.
  assign w_we_n_next = ~(r_is_write & (w_cnt_inc < LP_WAIT));

`ifdef SRAM_CTRL_ADDR_CHECK_EN
  assign w_addr_bad = (bus.address < 32'd1024)
                    | (bus.address >= 32'd525312)   // 1024 + 2^19
                    | (bus.address[1:0] != 2'b00);
`else
  logic w_unused_addr_bits;
  assign w_addr_bad         = 1'b0;
  assign w_unused_addr_bits = ^{bus.address[31:19], bus.address[1:0]};
`endif

  // ready is combinational so an idle request stalls the pipeline in the
  // very cycle it is accepted.
  assign bus.ready     = (r_state == S_DONE) ||
                         ((r_state == S_IDLE) && !w_req);
  assign bus.read_data = r_read_data;
  assign bus.addr_err  = r_addr_err;

  assign sram_addr     = r_sram_addr;
  assign sram_we_n     = r_sram_we_n;
  assign sram_dq_out   = r_sram_dq_out;
  assign sram_dq_oe    = r_sram_dq_oe;

  // SRAM pin registers are loaded with the values belonging to the state
  // being entered, so they are glitch-free and line up with r_state/r_cnt.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 3'd0;
      r_is_write    <= 1'b0;
      r_word        <= '0;
      r_wdata       <= '0;
      r_read_data   <= '0;
      r_addr_err    <= 1'b0;
      r_sram_addr   <= '0;
      r_sram_we_n   <= 1'b1;
      r_sram_dq_out <= '0;
      r_sram_dq_oe  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_is_write <= w_req_write;
            r_word     <= w_word;
            r_wdata    <= bus.write_data;
            r_cnt      <= 3'd0;
            if (w_addr_bad) begin
              // Rejected request: flag it for the single DONE cycle only.
              r_state    <= S_DONE;
              r_addr_err <= 1'b1;
            end else begin
              r_state       <= S_LO;
              r_sram_addr   <= {w_word, 1'b0};
              // WAIT_CYCLES >= 1, so cnt=0 is always inside the strobe window.
              r_sram_we_n   <= ~w_req_write;
              r_sram_dq_oe  <= w_req_write;
              r_sram_dq_out <= w_req_write ? bus.write_data[15:0] : 16'h0000;
            end
          end
        end

        S_LO: begin
          if (r_cnt == LP_WAIT) begin
            if (!r_is_write) r_read_data[15:0] <= sram_dq_in;
            r_state       <= S_HI;
            r_cnt         <= 3'd0;
            r_sram_addr   <= {r_word, 1'b1};
            r_sram_we_n   <= ~r_is_write;
            r_sram_dq_out <= r_is_write ? r_wdata[31:16] : 16'h0000;
          end else begin
            r_cnt       <= w_cnt_inc;
            r_sram_we_n <= w_we_n_next;
          end
        end

        S_HI: begin
          if (r_cnt == LP_WAIT) begin
            if (!r_is_write) r_read_data[31:16] <= sram_dq_in;
            r_state       <= S_DONE;
            r_cnt         <= 3'd0;
            r_sram_addr   <= '0;
            r_sram_we_n   <= 1'b1;
            r_sram_dq_oe  <= 1'b0;
            r_sram_dq_out <= 16'h0000;
          end else begin
            r_cnt       <= w_cnt_inc;
            r_sram_we_n <= w_we_n_next;
          end
        end

        S_DONE: begin
          r_state    <= S_IDLE;
          r_addr_err <= 1'b0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, extra cycles per 16-bit half access (legal range 1..7).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock, sole clock.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 wr_en  in  1  write request from the EXE/MEM boundary (level, held until ready).
REQ-005 rd_en  in  1  read request (level, held until ready).
REQ-006 address  in  32  byte address (ALU result).
REQ-007 write_data  in  32  store data (forwarded Rm value).
REQ-008 read_data  out  32  load data, valid in the cycle ready=1 after a read.
REQ-009 ready  out  1  0 = freeze pipeline; 1 = access complete or none pending.
REQ-010 addr_err  out  1  illegal-address flag (see Configuration).
REQ-011 sram_addr  out  18  SRAM half-word address.
REQ-012 sram_we_n  out  1  SRAM write strobe, active low.
REQ-013 sram_dq_out  out  16  SRAM write data; sram_dq_oe  out  1  drive enable; sram_dq_in  in  16  SRAM read data.

Function
REQ-014 SHALL implement FSM states IDLE, LO, HI, DONE, plus a 3-bit wait counter cnt.
REQ-015 IDLE: if wr_en or rd_en sampled 1, SHALL latch address, write_data, op type; go to LO, cnt=0.
REQ-016 wr_en and rd_en both 1 SHALL be treated as a write; rd_en ignored.
REQ-017 LO/HI: cnt SHALL increment each cycle; at cnt==WAIT_CYCLES, LO->HI (cnt=0), HI->DONE.
REQ-018 DONE SHALL last exactly one cycle then go to IDLE.
REQ-019 ready SHALL be 1 in DONE, 1 in IDLE with no request, 0 in all other cases (combinational on state, wr_en, rd_en).
REQ-020 Latency: DONE SHALL occur 2*(WAIT_CYCLES+1)+1 cycles after the accepting IDLE cycle (7 for default).
REQ-021 word = (address - 1024) >> 2; sram_addr SHALL be {word[16:0], 0} in LO, {word[16:0], 1} in HI; 0 in IDLE/DONE.
REQ-022 Write: sram_dq_oe=1 throughout LO/HI; sram_dq_out = write_data[15:0] in LO, [31:16] in HI.
REQ-023 Write: sram_we_n=0 while cnt<WAIT_CYCLES, 1 at cnt==WAIT_CYCLES and in all other states.
REQ-024 Read: sram_dq_oe=0; sram_dq_in SHALL be captured into read_data[15:0] at LO cnt==WAIT_CYCLES and into [31:16] at HI cnt==WAIT_CYCLES.
REQ-025 read_data SHALL hold its value until the next read capture; writes SHALL NOT alter it.
REQ-026 A request still asserted in the IDLE cycle following DONE SHALL start a new access.
REQ-027 Input changes while in LO/HI/DONE SHALL be ignored.

Reset
REQ-028 rst=1 at any cycle, including mid-access, SHALL force state IDLE, cnt=0, read_data=0, addr_err=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0 on the next edge; an aborted access SHALL NOT complete.

Configuration
REQ-029 Macro SRAM_CTRL_ADDR_CHECK_EN defined: a request with address<1024, address>=1024+2^19, or address[1:0]!=0 SHALL go IDLE->DONE directly, with no SRAM activity (sram_we_n=1, oe=0), addr_err=1 and read_data unchanged, during DONE only.
REQ-030 Macro undefined: no check; addr_err SHALL be constant 0; address bits beyond the mapping SHALL be ignored.

Verification
REQ-031 Write address=1028, data=0xDEADBEEF, WAIT_CYCLES=2 -> sram_addr 2 then 3, dq_out 0xBEEF then 0xDEAD, we_n low 2 cycles per half, ready=1 exactly 7 cycles after acceptance.
REQ-032 Read address=1028 with model returning 0xBEEF/0xDEAD -> read_data=0xDEADBEEF when ready=1, oe=0 throughout.
REQ-033 wr_en=rd_en=1 -> write performed, read_data unchanged.
REQ-034 rst asserted in HI during write -> next cycle IDLE, we_n=1, oe=0, ready=1 with no request.
REQ-035 Request held across DONE -> second access begins in IDLE cycle after DONE, ready low again.
REQ-036 With SRAM_CTRL_ADDR_CHECK_EN: read address=1000 -> ready=1 and addr_err=1 one cycle after acceptance, no SRAM strobes; without: addr_err stays 0.
